dac_channel_ctrl: RTL and testbench
===================================

DAC_CHANNEL_CTRL -- requirements
Module: dac_channel_ctrl

Interface
REQ-001 Parameter DW, default 12: DAC code width in bits, legal range 8..16.
REQ-002 Parameter NCH, default 4: number of DAC channels, legal range 1..16.
REQ-003 Parameter STEP, default 32: increment/decrement size, 1 <= STEP < 2^DW.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles to wait for dacdone.
REQ-005 CLK50MHZ input 1: sole clock; all logic on rising edge.
REQ-006 RST input 1: asynchronous, active-low reset (0 = reset asserted).
REQ-007 less input 1: one-cycle request to decrement the selected channel.
REQ-008 more input 1: one-cycle request to increment the selected channel.
REQ-009 ch_sel input 4: target channel index; values >= NCH are invalid.
REQ-010 all input 1: with less/more, apply the step to every channel and broadcast.
REQ-011 SW input 4: LED display select.
REQ-012 dacdone input 1: SPI DAC driver reports the transfer complete.
REQ-013 dac_datareceived input 32: word shifted back by the SPI driver.
REQ-014 data output DW: code presented to the SPI driver.
REQ-015 address output 4: DAC address; channel index, or 4'b1111 for a broadcast.
REQ-016 command output 4: fixed 4'b0011 (write and update).
REQ-017 dactrig output 1: one-cycle start pulse to the SPI driver.
REQ-018 busy output 1: high whenever the FSM is not in IDLE.
REQ-019 err output 1: sticky flag set on timeout or on an invalid ch_sel.
REQ-020 LED output 8: debug display.

Function
REQ-021 One DW-bit value register per channel shall hold that channel's last commanded code.
REQ-022 Decrement shall saturate: if value < STEP the result is 0, else value-STEP, using unsigned compare with no wrap.
REQ-023 Increment shall saturate: if value > MAXV-STEP the result is MAXV (all ones), else value+STEP.
REQ-024 The FSM states shall be IDLE, LOAD, TRIG and WAIT.
REQ-025 IDLE: if exactly one of less/more is high, the FSM shall update the target register(s) and go to LOAD; if both are high, it shall stay in IDLE and change nothing.
REQ-026 LOAD: the FSM shall drive data, address and command for the current transaction and go to TRIG.
REQ-027 TRIG: the FSM shall assert dactrig for exactly this one cycle and go to WAIT.
REQ-028 WAIT: on dacdone the FSM shall capture dac_datareceived into the readback register and go to IDLE.
REQ-029 WAIT: after TIMEOUT cycles without dacdone the FSM shall set err and go to IDLE, leaving readback unchanged.
REQ-030 Broadcast (all=1): the step shall apply to all NCH registers, address = 4'b1111, and data = the new value of channel 0.
REQ-031 In IDLE, an invalid ch_sel with all=0 shall set err, start no transaction and leave every register unchanged.
REQ-032 A less/more seen while busy shall be latched into a one-deep pending slot (direction, ch_sel, all); later requests while the slot is full shall be dropped.
REQ-033 On return to IDLE with the slot full, the pending request shall be serviced on the next cycle and the slot cleared.
REQ-034 data, address and command shall hold their values from LOAD until the next LOAD.
REQ-035 With dacdone asserted in the same cycle as dactrig, the FSM shall still enter WAIT and complete on the first WAIT cycle that sees dacdone.
REQ-036 LED: SW=0 shows the selected channel's value[DW-1:DW-8]; SW=8/4/2/1 shows readback byte [31:24]/[23:16]/[15:8]/[7:0].
REQ-037 LED for any other SW value shall be {err, pending, busy, 1'b0, ch_sel}.
REQ-038 err shall clear only on reset.

Reset
REQ-039 While RST=0, all channel values, data and readback shall be 0; address shall be 4'b1111.
REQ-040 While RST=0, dactrig, busy, err and pending shall be 0, and the state shall be IDLE.
REQ-041 A reset asserted mid-transaction shall abort it immediately; no dactrig shall be issued after release without a new request.

Verification
REQ-042 Defaults, ch_sel=2: three more pulses each answered by dacdone -> data 32, 64, 96, address 2, one dactrig per transaction.
REQ-043 Channel 1 at 4064 (0xFE0), more -> data 4095; channel 1 at 16, less -> 0; no wrap in either case.
REQ-044 less and more asserted together in IDLE -> no dactrig, busy stays 0, all values unchanged.
REQ-045 Two more pulses during WAIT, then dacdone -> exactly one extra transaction; second request dropped; final value +64 from start.
REQ-046 dacdone withheld -> err=1 after 1024 WAIT cycles, FSM back in IDLE; next request works normally with err still 1.
REQ-047 all=1 with more from all-zero -> address 4'b1111, data 32, every channel register reads 32 via LED with SW=0.

Source files
------------

// File: rtl/dac_channel_ctrl.sv
// DAC channel controller: per-channel saturating step registers, SPI DAC
// handshake FSM with timeout, one-deep pending request slot and LED debug view.
module dac_channel_ctrl #(
    parameter int unsigned DW      = 12,
    parameter int unsigned NCH     = 4,
    parameter int unsigned STEP    = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          CLK50MHZ,
    input  logic          RST,
    input  logic          less,
    input  logic          more,
    input  logic [3:0]    ch_sel,
    input  logic          all,
    input  logic [3:0]    SW,
    input  logic          dacdone,
    input  logic [31:0]   dac_datareceived,
    output logic [DW-1:0] data,
    output logic [3:0]    address,
    output logic [3:0]    command,
    output logic          dactrig,
    output logic          busy,
    output logic          err,
    output logic [7:0]    LED
);

    localparam int unsigned   CW               = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] MAXV             = {DW{1'b1}};
    localparam logic [DW-1:0] STEPV            = DW'(STEP);
    localparam logic [3:0]    CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0]    ADDR_BCAST       = 4'b1111;

    typedef enum logic [1:0] {IDLE, LOAD, TRIG, WAIT} state_t;

    state_t        state;
    state_t        state_n;

    logic [DW-1:0] val_q [NCH];
    logic [DW-1:0] val_n [NCH];
    logic [31:0]   readback;
    logic          pend_v;
    logic          pend_up;
    logic          pend_all;
    logic [3:0]    pend_ch;
    logic [CW-1:0] wait_cnt;

    logic          req_v;
    logic          req_up;
    logic          req_all;
    logic          req_ok;
    logic [3:0]    req_ch;
    logic          start;
    logic          set_err;
    logic          capture;
    logic          pend_set;
    logic          pend_clr;
    logic [DW-1:0] tgt_val;
    logic [DW-1:0] load_val;
    logic [DW-1:0] sel_val;
    logic [7:0]    led_n;

    // Saturating step: clamps at 0 going down and at all-ones going up.
    function automatic logic [DW-1:0] step_code(input logic [DW-1:0] v, input logic up);
        if (up) begin
            return (v > (MAXV - STEPV)) ? MAXV : (v + STEPV);
        end
        return (v < STEPV) ? {DW{1'b0}} : (v - STEPV);
    endfunction

    // Request source: a parked request takes priority over the live inputs.
    always_comb begin
        req_v   = pend_v | (less ^ more);
        req_up  = pend_v ? pend_up  : more;
        req_all = pend_v ? pend_all : all;
        req_ch  = pend_v ? pend_ch  : ch_sel;
        req_ok  = req_all | ({1'b0, req_ch} < 5'(NCH));
    end

    // Next-state and transaction control.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        set_err = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (req_v) begin
                    if (req_ok) begin
                        start   = 1'b1;
                        state_n = LOAD;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            LOAD: state_n = TRIG;
            TRIG: state_n = WAIT;
            WAIT: begin
                if (dacdone) begin
                    capture = 1'b1;
                    state_n = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pending slot control: park one request while busy, release it in IDLE.
    always_comb begin
        pend_set = (state != IDLE) & ~pend_v & (less ^ more);
        pend_clr = (state == IDLE) & pend_v;
    end

    // Channel next values, code for the SPI driver, and LED channel view.
    always_comb begin
        tgt_val = '0;
        sel_val = '0;
        for (int i = 0; i < NCH; i++) begin
            val_n[i] = val_q[i];
            if (start && (req_all || (4'(i) == req_ch))) begin
                val_n[i] = step_code(val_q[i], req_up);
            end
            if (4'(i) == req_ch) begin
                tgt_val = val_n[i];
            end
            if (4'(i) == ch_sel) begin
                sel_val = val_q[i];
            end
        end
        load_val = req_all ? val_n[0] : tgt_val;
    end

    // Debug display mux.
    always_comb begin
        led_n = {err, pend_v, busy, 1'b0, ch_sel};
        case (SW)
            4'd0: led_n = sel_val[DW-1 -: 8];
            4'd8: led_n = readback[31:24];
            4'd4: led_n = readback[23:16];
            4'd2: led_n = readback[15:8];
            4'd1: led_n = readback[7:0];
            default: led_n = {err, pend_v, busy, 1'b0, ch_sel};
        endcase
    end

    // State register.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Channel value registers.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= val_n[i];
            end
        end
    end

    // SPI driver interface and status outputs.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            data    <= '0;
            address <= ADDR_BCAST;
            command <= CMD_WRITE_UPDATE;
            dactrig <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            dactrig <= (state_n == TRIG);
            busy    <= (state_n != IDLE);
            err     <= err | set_err;
            if (start) begin
                data    <= load_val;
                address <= req_all ? ADDR_BCAST : req_ch;
                command <= CMD_WRITE_UPDATE;
            end
        end
    end

    // Pending request slot.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            pend_v   <= 1'b0;
            pend_up  <= 1'b0;
            pend_all <= 1'b0;
            pend_ch  <= '0;
        end else if (pend_set) begin
            pend_v   <= 1'b1;
            pend_up  <= more;
            pend_all <= all;
            pend_ch  <= ch_sel;
        end else if (pend_clr) begin
            pend_v   <= 1'b0;
        end
    end

    // WAIT-state cycle counter for the dacdone timeout.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? (wait_cnt + CW'(1)) : '0;
        end
    end

    // Readback capture and LED register.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            readback <= '0;
            LED      <= '0;
        end else begin
            if (capture) begin
                readback <= dac_datareceived;
            end
            LED <= led_n;
        end
    end

endmodule

// File: tb/tb_dac_channel_ctrl.sv
// Directed scoreboard bench for dac_channel_ctrl (default parameters).
module tb_dac_channel_ctrl;

    localparam int unsigned DW  = 12;
    localparam int unsigned NCH = 4;

    logic          CLK50MHZ = 1'b0;
    logic          RST      = 1'b1;
    logic          less     = 1'b0;
    logic          more     = 1'b0;
    logic [3:0]    ch_sel   = 4'd0;
    logic          all      = 1'b0;
    logic [3:0]    SW       = 4'd0;
    logic          dacdone  = 1'b0;
    logic [31:0]   dac_datareceived = 32'd0;
    logic [DW-1:0] data;
    logic [3:0]    address;
    logic [3:0]    command;
    logic          dactrig;
    logic          busy;
    logic          err;
    logic [7:0]    LED;

    typedef struct packed {
        logic [DW-1:0] code;
        logic [3:0]    addr;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    ntrig  = 0;
    int    mval[NCH];

    dac_channel_ctrl dut (
        .CLK50MHZ         (CLK50MHZ),
        .RST              (RST),
        .less             (less),
        .more             (more),
        .ch_sel           (ch_sel),
        .all              (all),
        .SW               (SW),
        .dacdone          (dacdone),
        .dac_datareceived (dac_datareceived),
        .data             (data),
        .address          (address),
        .command          (command),
        .dactrig          (dactrig),
        .busy             (busy),
        .err              (err),
        .LED              (LED)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int msat(input int v, input bit up);
        int r;
        r = up ? (v + 32) : (v - 32);
        if (r > 4095) r = 4095;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_req(input bit up, input int ch, input bit a);
        exp_t e;
        if (a) begin
            for (int i = 0; i < NCH; i++) mval[i] = msat(mval[i], up);
            e.code = DW'(mval[0]);
            e.addr = 4'hF;
        end else begin
            mval[ch] = msat(mval[ch], up);
            e.code = DW'(mval[ch]);
            e.addr = 4'(ch);
        end
        sb.push_back(e);
    endtask

    task automatic issue(input bit l, input bit m, input int ch, input bit a);
        ch_sel = 4'(ch);
        all    = a;
        less   = l;
        more   = m;
        tick();
        less   = 1'b0;
        more   = 1'b0;
    endtask

    // Waits for dactrig, scores data/address against the queue head, then
    // steps one cycle into WAIT.
    task automatic expect_txn(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (dactrig === 1'b1) seen = 1'b1;
        end
        if (seen) ntrig++;
        chk({tag, "_trig"}, 32'(seen), 32'd1);
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(data), 32'(e.code));
            chk({tag, "_addr"}, 32'(address), 32'(e.addr));
        end
        chk({tag, "_cmd"}, 32'(command), 32'h3);
        tick();
        chk({tag, "_trig_pulse"}, 32'(dactrig), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic respond(input logic [31:0] rb);
        dac_datareceived = rb;
        dacdone = 1'b1;
        tick();
        dacdone = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic no_trig(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (dactrig !== 1'b0) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    task automatic led_chk(input logic [3:0] sw, input int ch, input logic [7:0] exp, input string tag);
        SW = sw;
        ch_sel = 4'(ch);
        tick();
        tick();
        chk(tag, 32'(LED), 32'(exp));
    endtask

    task automatic do_reset();
        RST = 1'b0;
        less = 1'b0;
        more = 1'b0;
        dacdone = 1'b0;
        #2;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_addr", 32'(address), 32'hF);
        chk("rst_trig", 32'(dactrig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        chk("rst_led", 32'(LED), 32'd0);
        RST = 1'b1;
        tick();
        for (int i = 0; i < NCH; i++) mval[i] = 0;
        sb.delete();
    endtask

    initial begin
        int n;
        #5;
        do_reset();
        led_chk(4'd1, 0, 8'h00, "rst_readback");

        // Three increments on channel 2.
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b1, 2, 1'b0);
            model_req(1'b1, 2, 1'b0);
            expect_txn("ch2_more");
            respond(32'h1234_5600 + 32'(k));
        end
        chk("ch2_ntrig", 32'(ntrig), 32'd3);
        chk("ch2_data96", 32'(data), 32'd96);
        led_chk(4'd8, 2, 8'h12, "led_rb3");
        led_chk(4'd4, 2, 8'h34, "led_rb2");
        led_chk(4'd2, 2, 8'h56, "led_rb1");
        led_chk(4'd1, 2, 8'h02, "led_rb0");
        led_chk(4'd0, 2, 8'h06, "led_ch2");

        // Upper saturation on channel 1.
        for (int k = 0; k < 127; k++) begin
            issue(1'b0, 1'b1, 1, 1'b0);
            model_req(1'b1, 1, 1'b0);
            expect_txn("ch1_up");
            respond(32'd0);
        end
        chk("ch1_4064", 32'(data), 32'd4064);
        issue(1'b0, 1'b1, 1, 1'b0);
        model_req(1'b1, 1, 1'b0);
        expect_txn("ch1_sat_hi");
        respond(32'd0);
        chk("ch1_4095", 32'(data), 32'd4095);

        // Lower saturation on channel 1 from a value below STEP.
        for (int k = 0; k < 127; k++) begin
            issue(1'b1, 1'b0, 1, 1'b0);
            model_req(1'b0, 1, 1'b0);
            expect_txn("ch1_dn");
            respond(32'd0);
        end
        chk("ch1_31", 32'(data), 32'd31);
        issue(1'b1, 1'b0, 1, 1'b0);
        model_req(1'b0, 1, 1'b0);
        expect_txn("ch1_sat_lo");
        respond(32'd0);
        chk("ch1_0", 32'(data), 32'd0);
        issue(1'b1, 1'b0, 1, 1'b0);
        model_req(1'b0, 1, 1'b0);
        expect_txn("ch1_stay0");
        respond(32'd0);
        chk("ch1_still0", 32'(data), 32'd0);

        // less and more together: no transaction.
        issue(1'b1, 1'b1, 2, 1'b0);
        chk("both_busy", 32'(busy), 32'd0);
        no_trig(8, "both_no_trig");
        chk("both_busy_after", 32'(busy), 32'd0);
        led_chk(4'd0, 2, 8'h06, "both_ch2_same");

        // Two requests during WAIT: one parked, one dropped.
        issue(1'b0, 1'b1, 2, 1'b0);
        model_req(1'b1, 2, 1'b0);
        expect_txn("pend_first");
        issue(1'b0, 1'b1, 2, 1'b0);
        model_req(1'b1, 2, 1'b0);
        issue(1'b0, 1'b1, 2, 1'b0);
        respond(32'hCAFE_0001);
        expect_txn("pend_second");
        respond(32'hCAFE_0002);
        no_trig(20, "pend_drop");
        chk("pend_data160", 32'(data), 32'd160);
        led_chk(4'd0, 2, 8'h0A, "pend_led_ch2");

        // Reset in the middle of a transaction.
        issue(1'b0, 1'b1, 0, 1'b0);
        model_req(1'b1, 0, 1'b0);
        expect_txn("abort");
        do_reset();
        no_trig(20, "abort_no_trig");

        // Broadcast from all-zero.
        issue(1'b0, 1'b1, 0, 1'b1);
        model_req(1'b1, 0, 1'b1);
        expect_txn("bcast");
        respond(32'h0000_00B7);
        for (int i = 0; i < NCH; i++) led_chk(4'd0, i, 8'h02, "bcast_led");

        // dacdone withheld: timeout.
        issue(1'b0, 1'b1, 1, 1'b0);
        model_req(1'b1, 1, 1'b0);
        expect_txn("to_txn");
        n = 1;
        while (busy === 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd1025);
        chk("to_err", 32'(err), 32'd1);
        led_chk(4'd1, 1, 8'hB7, "to_rb_kept");
        issue(1'b0, 1'b1, 1, 1'b0);
        model_req(1'b1, 1, 1'b0);
        expect_txn("after_to");
        respond(32'h0000_00C3);
        chk("after_to_data", 32'(data), 32'd96);
        chk("after_to_err", 32'(err), 32'd1);
        led_chk(4'd1, 1, 8'hC3, "after_to_rb");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Invalid channel select.
        do_reset();
        issue(1'b0, 1'b1, 5, 1'b0);
        no_trig(8, "inv_no_trig");
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_busy", 32'(busy), 32'd0);
        led_chk(4'hF, 5, 8'h85, "inv_led_status");
        for (int i = 0; i < NCH; i++) led_chk(4'd0, i, 8'h00, "inv_vals");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
